// File: rtl/params_checker.sv
// rtl/params_checker.sv - samples parameter readback outputs, checks them against expected values, reports a 4-byte mismatch stream
module params_checker #(
    parameter int         EXP_BOO     = 0,
    parameter int         EXP_INT     = 0,
    parameter logic       EXP_LOG     = 1'b0,
    parameter logic [7:0] EXP_VEC     = 8'd0,
    parameter int         EXP_STR     = 0,
    parameter int         EXP_REA     = 0,
    parameter int         SETTLE_CYC  = 4,
    parameter int         TIMEOUT_CYC = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       boo_i,
    input  logic [7:0] int_i,
    input  logic       log_i,
    input  logic [7:0] vec_i,
    input  logic       str_i,
    input  logic       rea_i,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [7:0] mask_o
);

    localparam int            CW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] STAB_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYC - 1);
    localparam logic          EXP_BOO_B = 1'(EXP_BOO);
    localparam logic [7:0]    EXP_INT_B = 8'(EXP_INT);
    localparam logic          EXP_STR_B = 1'(EXP_STR);
    localparam logic          EXP_REA_B = 1'(EXP_REA);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_REPORT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    // Snapshot layout: rea[19] str[18] vec[17:10] log[9] int[8:1] boo[0]
    logic [19:0]   sample, snap;
    logic [CW-1:0] stab, tmo;
    logic [2:0]    idx;
    logic [1:0]    bidx;
    logic [7:0]    mask;
    logic          pass;
    logic          stable, timed_out, field_bad;
    logic [7:0]    tx_data;

    assign sample = {rea_i, str_i, vec_i, log_i, int_i, boo_i};
    assign stable = (sample == snap);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timed_out = 1'b0;
        case (state)
            S_IDLE:   if (start_i) state_nxt = S_SETTLE;
            S_SETTLE: begin
                if (stable && stab == STAB_LAST) begin
                    state_nxt = S_CHECK;
                end else if (tmo == TMO_LAST) begin
                    state_nxt = S_CHECK;
                    timed_out = 1'b1;
                end
            end
            S_CHECK:  if (idx == 3'd5) state_nxt = S_REPORT;
            S_REPORT: if (tx_ready_i && bidx == 2'd3) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        field_bad = 1'b0;
        case (idx)
            3'd0:    field_bad = (snap[0] != EXP_BOO_B);
            3'd1:    field_bad = (snap[8:1] != EXP_INT_B);
            3'd2:    field_bad = (snap[9] != EXP_LOG);
            3'd3:    field_bad = (snap[17:10] != EXP_VEC);
            3'd4:    field_bad = (snap[18] != EXP_STR_B);
            3'd5:    field_bad = (snap[19] != EXP_REA_B);
            default: field_bad = 1'b0;
        endcase
    end

    always_comb begin
        tx_data = 8'h00;
        if (state == S_REPORT) begin
            case (bidx)
                2'd0:    tx_data = 8'hA5;
                2'd1:    tx_data = mask;
                2'd2:    tx_data = snap[8:1];
                default: tx_data = snap[17:10];
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            snap <= '0;
            stab <= '0;
            tmo  <= '0;
            idx  <= '0;
            bidx <= '0;
            mask <= '0;
            pass <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    idx <= '0;
                    if (start_i) begin
                        mask <= '0;
                        pass <= 1'b0;
                        snap <= sample;
                        stab <= '0;
                        tmo  <= '0;
                    end
                end
                S_SETTLE: begin
                    tmo <= tmo + 1'b1;
                    idx <= '0;
                    if (stable) begin
                        stab <= stab + 1'b1;
                    end else begin
                        snap <= sample;
                        stab <= '0;
                    end
                    if (timed_out) mask[7] <= 1'b1;
                end
                S_CHECK: begin
                    if (field_bad) mask[idx] <= 1'b1;
                    idx  <= idx + 1'b1;
                    bidx <= '0;
                end
                S_REPORT: if (tx_ready_i) bidx <= bidx + 1'b1;
                S_DONE:   pass <= (mask == 8'h00);
                default:  ;
            endcase
        end
    end

    // Stream and status outputs decode straight from state so reset clears them at once.
    assign tx_data_o  = tx_data;
    assign tx_valid_o = (state == S_REPORT);
    assign busy_o     = (state != S_IDLE);
    assign done_o     = (state == S_DONE);
    assign pass_o     = pass;
    assign mask_o     = mask;

endmodule

// File: tb/tb_params_checker.sv
// tb/tb_params_checker.sv - randomized and directed self-checking bench for params_checker
module tb_params_checker;

    localparam int         P_BOO = 1;
    localparam int         P_INT = 300;
    localparam logic       P_LOG = 1'b1;
    localparam logic [7:0] P_VEC = 8'hC3;
    localparam int         P_STR = 2;
    localparam int         P_REA = 1;

    localparam logic       E_BOO = 1'(P_BOO % 2);
    localparam logic [7:0] E_INT = 8'(P_INT % 256);
    localparam logic       E_LOG = P_LOG;
    localparam logic [7:0] E_VEC = P_VEC;
    localparam logic       E_STR = 1'(P_STR % 2);
    localparam logic       E_REA = 1'(P_REA % 2);

    logic       clk_i = 1'b0;
    logic       rst_i, start_i, boo_i, log_i, str_i, rea_i, tx_ready_i;
    logic [7:0] int_i, vec_i;
    logic [7:0] tx_data_o, mask_o;
    logic       tx_valid_o, busy_o, done_o, pass_o;

    always #5 clk_i = ~clk_i;

    params_checker #(
        .EXP_BOO(P_BOO), .EXP_INT(P_INT), .EXP_LOG(P_LOG), .EXP_VEC(P_VEC),
        .EXP_STR(P_STR), .EXP_REA(P_REA), .SETTLE_CYC(4), .TIMEOUT_CYC(64)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .boo_i(boo_i), .int_i(int_i), .log_i(log_i), .vec_i(vec_i),
        .str_i(str_i), .rea_i(rea_i),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .mask_o(mask_o)
    );

    int         total = 0;
    int         bad   = 0;
    logic [7:0] got[$];
    int         n_done, hold_bad, first_c, done_c;
    bit         finished;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic kick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Mismatch mask derived field by field from the expected parameter values.
    function automatic logic [7:0] model_mask(input logic b, input logic [7:0] iv, input logic l,
                                              input logic [7:0] v, input logic s, input logic r,
                                              input bit to);
        logic [7:0] m;
        m    = 8'h00;
        m[0] = (b != E_BOO);
        m[1] = (iv != E_INT);
        m[2] = (l != E_LOG);
        m[3] = (v != E_VEC);
        m[4] = (s != E_STR);
        m[5] = (r != E_REA);
        m[7] = to;
        return m;
    endfunction

    task automatic run_report(input int ready_pct, input int stall_byte, input int stall_len, input bit poke);
        bit         prev_stall;
        logic [7:0] prev_data;
        int         stall_cnt;
        got.delete();
        n_done = 0; hold_bad = 0; first_c = -1; done_c = -1; finished = 0;
        prev_stall = 0; prev_data = 8'h00; stall_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            start_i = poke && (c == 6 || c == 12);
            if (tx_valid_o && got.size() == stall_byte && stall_cnt < stall_len) begin
                tx_ready_i = 1'b0;
                stall_cnt++;
            end else begin
                tx_ready_i = ($urandom_range(99) < ready_pct);
            end
            if (prev_stall && (!tx_valid_o || tx_data_o !== prev_data)) hold_bad++;
            if (tx_valid_o && first_c < 0) first_c = c;
            if (tx_valid_o && tx_ready_i) got.push_back(tx_data_o);
            prev_stall = tx_valid_o && !tx_ready_i;
            prev_data  = tx_data_o;
            if (done_o) begin
                n_done++;
                done_c = c;
            end
            if (n_done > 0 && !busy_o) begin
                finished = 1;
                break;
            end
            tick();
        end
        start_i    = 1'b0;
        tx_ready_i = 1'b1;
    endtask

    task automatic verify(input string tag, input logic [7:0] em, input logic [7:0] ei,
                          input logic [7:0] ev, input bit cv);
        int q;
        chk({tag, "_finished"}, 32'(finished), 32'd1);
        chk({tag, "_nbytes"}, 32'(got.size()), 32'd4);
        if (got.size() == 4) begin
            chk({tag, "_byte0"}, 32'(got[0]), 32'hA5);
            chk({tag, "_byte1"}, 32'(got[1]), 32'(em));
            chk({tag, "_byte2"}, 32'(got[2]), 32'(ei));
            if (cv) chk({tag, "_byte3"}, 32'(got[3]), 32'(ev));
        end
        chk({tag, "_mask"}, 32'(mask_o), 32'(em));
        chk({tag, "_pass"}, 32'(pass_o), 32'(em == 8'h00));
        chk({tag, "_ndone"}, 32'(n_done), 32'd1);
        chk({tag, "_hold"}, 32'(hold_bad), 32'd0);
        q = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done_o || busy_o || tx_valid_o) q++;
        end
        chk({tag, "_quiet"}, 32'(q), 32'd0);
    endtask

    task automatic drive_expected();
        boo_i = E_BOO; int_i = E_INT; log_i = E_LOG;
        vec_i = E_VEC; str_i = E_STR; rea_i = E_REA;
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; tx_ready_i = 1'b0;
        boo_i = 0; int_i = 0; log_i = 0; vec_i = 0; str_i = 0; rea_i = 0;
        tick();
        tick();
        chk("reset_outs", 32'({tx_data_o, tx_valid_o, busy_o, done_o, pass_o, mask_o}), 32'd0);
        rst_i = 1'b0;
        tx_ready_i = 1'b1;
        tick();
        chk("idle_busy", 32'(busy_o), 32'd0);

        // T1: matching inputs, ready tied high, latency check
        drive_expected();
        kick();
        chk("t1_busy", 32'(busy_o), 32'd1);
        run_report(100, -1, 0, 0);
        chk("t1_first_valid", 32'(first_c), 32'd10);
        chk("t1_done_cycle", 32'(done_c), 32'd14);
        verify("t1", 8'h00, E_INT, E_VEC, 1);

        // T2: int and vec wrong
        drive_expected();
        int_i = E_INT ^ 8'h01;
        vec_i = ~E_VEC;
        kick();
        run_report(100, -1, 0, 0);
        verify("t2", 8'h0A, E_INT ^ 8'h01, ~E_VEC, 1);

        // T3: vec never settles, timeout flag
        drive_expected();
        vec_i = E_VEC ^ 8'h01;
        kick();
        for (int k = 1; k <= 64; k++) begin
            vec_i = (k % 2 == 1) ? (E_VEC ^ 8'h02) : (E_VEC ^ 8'h01);
            if (k == 64) chk("t3_pre_timeout", 32'(mask_o), 32'd0);
            tick();
        end
        chk("t3_flag", 32'(mask_o), 32'h80);
        run_report(100, -1, 0, 0);
        verify("t3", 8'h88, E_INT, 8'h00, 0);

        // T4: sink stalls 5 cycles on byte 2
        drive_expected();
        int_i = 8'h5A;
        kick();
        run_report(100, 2, 5, 0);
        chk("t4_done_cycle", 32'(done_c), 32'd19);
        verify("t4", 8'h02, 8'h5A, E_VEC, 1);

        // T5: reset mid-report, then a fresh full run
        drive_expected();
        kick();
        for (int k = 0; k < 11; k++) tick();
        chk("t5_in_report", 32'(tx_valid_o), 32'd1);
        rst_i = 1'b1;
        #1;
        chk("t5_reset_outs", 32'({tx_data_o, tx_valid_o, busy_o, done_o, pass_o, mask_o}), 32'd0);
        tick();
        rst_i = 1'b0;
        tick();
        chk("t5_idle", 32'(busy_o), 32'd0);
        kick();
        run_report(100, -1, 0, 0);
        verify("t5", 8'h00, E_INT, E_VEC, 1);

        // T6: start pulses during CHECK and REPORT are ignored
        drive_expected();
        str_i = ~E_STR;
        kick();
        run_report(100, -1, 0, 1);
        verify("t6", 8'h10, E_INT, E_VEC, 1);

        // Randomized fields and sink back-pressure against the model
        for (int t = 0; t < 10; t++) begin
            logic [7:0] em;
            boo_i = ($urandom_range(1) == 1) ? E_BOO : 1'($urandom);
            int_i = ($urandom_range(1) == 1) ? E_INT : 8'($urandom);
            log_i = ($urandom_range(1) == 1) ? E_LOG : 1'($urandom);
            vec_i = ($urandom_range(1) == 1) ? E_VEC : 8'($urandom);
            str_i = ($urandom_range(1) == 1) ? E_STR : 1'($urandom);
            rea_i = ($urandom_range(1) == 1) ? E_REA : 1'($urandom);
            em = model_mask(boo_i, int_i, log_i, vec_i, str_i, rea_i, 0);
            kick();
            run_report(int'($urandom_range(30, 100)), -1, 0, 0);
            verify($sformatf("rand%0d", t), em, int_i, vec_i, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
